// File: rtl/snn_image_sequencer_pkg.sv
// Shared types and constants for the SNN image sequencer and snn_core.
//   state_t    : sequencer FSM state encoding
//   NUM_PIXELS : 1-bit input units per image
//   NUM_BYTES  : received bytes per image (NUM_PIXELS / 8)
//   ASCII_BASE : offset added to the classified digit before transmission
package snn_pkg;

  localparam int          NUM_PIXELS = 784;
  localparam int          NUM_BYTES  = NUM_PIXELS / 8;
  localparam logic [7:0]  ASCII_BASE = 8'h30;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_BYTE  = 3'd1,
    S_WRITE_BITS = 3'd2,
    S_START      = 3'd3,
    S_RUN        = 3'd4,
    S_TX_REQ     = 3'd5,
    S_TX_WAIT    = 3'd6
  } state_t;

endpackage

// File: rtl/snn_image_sequencer_rx_byte_buffer.sv
// One-entry hold register between the UART receiver and the bit unpacker.
// Ports:
//   clk, rst_n   : system clock, async active-low reset
//   rx_rdy       : received-byte strobe
//   rx_data      : received byte
//   take_direct  : unpacker consumes rx_data itself this cycle
//   hold_en      : a byte arriving now may be parked in the hold register
//   pop          : unpacker consumes the held byte this cycle
//   flush        : image complete; any held byte is discarded
//   hold_valid   : hold register full
//   hold_data    : held byte
//   overrun      : sticky, a byte was dropped
module rx_byte_buffer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_rdy,
  input  logic [7:0] rx_data,
  input  logic       take_direct,
  input  logic       hold_en,
  input  logic       pop,
  input  logic       flush,
  output logic       hold_valid,
  output logic [7:0] hold_data,
  output logic       overrun
);

  logic       full_q;
  logic [7:0] data_q;
  logic       ovr_q;
  logic       store;
  logic       drop;

  // A byte arriving in the same cycle the held one is consumed refills it.
  assign store = rx_rdy & hold_en & (~full_q | pop);
  assign drop  = (rx_rdy & ~take_direct & ~store) | (flush & full_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= 8'h00;
      ovr_q  <= 1'b0;
    end else begin
      if (store) begin
        full_q <= 1'b1;
        data_q <= rx_data;
      end else if (pop || flush) begin
        full_q <= 1'b0;
      end
      if (drop) ovr_q <= 1'b1;
    end
  end

  assign hold_valid = full_q;
  assign hold_data  = data_q;
  assign overrun    = ovr_q;

endmodule

// File: rtl/snn_image_sequencer.sv
// Sequencer between the UART and snn_core: unpacks a received image into the
// 1-bit input RAM, starts the core, then transmits the classified digit as ASCII.
// Ports:
//   clk, rst_n            : system clock, async active-low reset
//   rx_rdy, rx_data       : received byte strobe and data
//   core_addr             : input RAM address from snn_core while it runs
//   core_done, core_digit : classification complete and result
//   core_start            : one-cycle start pulse to snn_core
//   ram_addr, ram_d, ram_we : input RAM port
//   tx_busy               : UART transmitter busy
//   tx_start, tx_data     : transmit request and byte
//   digit_led             : last classified digit
//   busy                  : sequencer not idle
//   overrun               : sticky, a received byte was dropped
//
// state        | meaning
// -------------+---------------------------------------------------
// S_IDLE       | waiting for the first byte of an image
// S_WAIT_BYTE  | mid-image, waiting for the next byte
// S_WRITE_BITS | writing one bit per cycle, LSB first
// S_START      | one-cycle core_start pulse
// S_RUN        | core owns the RAM address port
// S_TX_REQ     | waiting for the transmitter to be free
// S_TX_WAIT    | waiting for the transmission to finish
module snn_image_sequencer
  import snn_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic              core_done,
  input  logic [3:0]        core_digit,
  output logic              core_start,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_d,
  output logic              ram_we,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        digit_led,
  output logic              busy,
  output logic              overrun
);

  state_t            state_q, state_d;
  logic [7:0]        shift_q;
  logic [2:0]        bit_cnt_q;
  logic [6:0]        byte_cnt_q;
  logic [ADDR_W-1:0] pix_addr_q;
  logic [3:0]        digit_q;
  logic [7:0]        tx_data_q;
  logic [1:0]        wait_cnt_q;
  logic              seen_busy_q;

  logic              last_bit;
  logic              last_byte;
  logic              image_end;
  logic              hold_valid;
  logic [7:0]        hold_data;
  logic              take_direct;
  logic              hold_en;
  logic              pop;

  assign last_bit  = (bit_cnt_q == 3'd7);
  assign last_byte = (byte_cnt_q == 7'(NUM_BYTES - 1));
  assign image_end = (state_q == S_WRITE_BITS) && last_bit && last_byte;

  // Image completion wins over a parked byte so pix_addr never passes the
  // last pixel; a byte parked at that point is dropped and flagged.
  assign take_direct = (state_q == S_IDLE) || (state_q == S_WAIT_BYTE);
  assign hold_en     = (state_q == S_WRITE_BITS) && !image_end;
  assign pop         = (state_q == S_WRITE_BITS) && last_bit && !last_byte && hold_valid;

  rx_byte_buffer u_rx_byte_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_rdy      (rx_rdy),
    .rx_data     (rx_data),
    .take_direct (take_direct),
    .hold_en     (hold_en),
    .pop         (pop),
    .flush       (image_end),
    .hold_valid  (hold_valid),
    .hold_data   (hold_data),
    .overrun     (overrun)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_WAIT_BYTE: if (rx_rdy) state_d = S_WRITE_BITS;
      S_WRITE_BITS: begin
        if (last_bit) begin
          if (last_byte)       state_d = S_START;
          else if (hold_valid) state_d = S_WRITE_BITS;
          else                 state_d = S_WAIT_BYTE;
        end
      end
      S_START:   state_d = S_RUN;
      S_RUN:     if (core_done) state_d = S_TX_REQ;
      S_TX_REQ:  if (!tx_busy) state_d = S_TX_WAIT;
      // Leave once busy has been seen and dropped, or if it never rose
      // within two cycles of the request.
      S_TX_WAIT: if (!tx_busy && (seen_busy_q || wait_cnt_q == 2'd1)) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    core_start = (state_q == S_START);
    ram_we     = (state_q == S_WRITE_BITS);
    ram_d      = (state_q == S_WRITE_BITS) & shift_q[0];
    ram_addr   = take_direct || (state_q == S_WRITE_BITS) ? pix_addr_q : core_addr;
    tx_start   = (state_q == S_TX_REQ) && !tx_busy;
    busy       = (state_q != S_IDLE);
    tx_data    = tx_data_q;
    digit_led  = digit_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q     <= 8'h00;
      bit_cnt_q   <= 3'd0;
      byte_cnt_q  <= 7'd0;
      pix_addr_q  <= '0;
      digit_q     <= 4'd0;
      tx_data_q   <= 8'h00;
      wait_cnt_q  <= 2'd0;
      seen_busy_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (rx_rdy) begin
            shift_q    <= rx_data;
            bit_cnt_q  <= 3'd0;
            byte_cnt_q <= 7'd0;
            pix_addr_q <= '0;
          end
        end
        S_WAIT_BYTE: begin
          if (rx_rdy) begin
            shift_q   <= rx_data;
            bit_cnt_q <= 3'd0;
          end
        end
        S_WRITE_BITS: begin
          bit_cnt_q <= bit_cnt_q + 3'd1;
          shift_q   <= shift_q >> 1;
          if (image_end) begin
            pix_addr_q <= '0;
            byte_cnt_q <= 7'd0;
          end else begin
            pix_addr_q <= pix_addr_q + 1'b1;
            if (last_bit) byte_cnt_q <= byte_cnt_q + 7'd1;
            if (pop)      shift_q    <= hold_data;
          end
        end
        S_RUN: begin
          if (core_done) begin
            digit_q   <= core_digit;
            tx_data_q <= ASCII_BASE + {4'h0, core_digit};
          end
        end
        S_TX_REQ: begin
          if (!tx_busy) begin
            wait_cnt_q  <= 2'd2;
            seen_busy_q <= 1'b0;
          end
        end
        S_TX_WAIT: begin
          if (tx_busy) seen_busy_q <= 1'b1;
          if (wait_cnt_q != 2'd0) wait_cnt_q <= wait_cnt_q - 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_snn_image_sequencer.sv
module tb_snn_image_sequencer;

  logic       clk;
  logic       rst_n;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic [9:0] core_addr;
  logic       core_done;
  logic [3:0] core_digit;
  logic       core_start;
  logic [9:0] ram_addr;
  logic       ram_d;
  logic       ram_we;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic [3:0] digit_led;
  logic       busy;
  logic       overrun;

  snn_image_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .core_addr  (core_addr),
    .core_done  (core_done),
    .core_digit (core_digit),
    .core_start (core_start),
    .ram_addr   (ram_addr),
    .ram_d      (ram_d),
    .ram_we     (ram_we),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .digit_led  (digit_led),
    .busy       (busy),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   vectors    = 0;
  int   miscompares = 0;
  int   cyc        = 0;
  int   we_cnt     = 0;
  int   start_cnt  = 0;
  int   txs_cnt    = 0;
  int   last_we_cyc = 0;
  int   start_cyc  = 0;
  int   first_addr = -1;
  bit   arm        = 1'b0;
  logic mem [0:1023];

  always @(posedge clk) cyc++;

  // RAM model and event counters, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      arm = 1'b1;
    end else begin
      if (ram_we) begin
        mem[ram_addr] = ram_d;
        we_cnt++;
        last_we_cyc = cyc;
        if (arm) begin
          first_addr = int'(ram_addr);
          arm = 1'b0;
        end
      end
      if (core_start) begin
        start_cnt++;
        start_cyc = cyc;
      end
      if (tx_start) txs_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_rdy  = 1'b1;
    rx_data = b;
    tick();
    rx_rdy  = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic wait_start(input string tag, input int base);
    int n;
    n = 0;
    while (start_cnt == base && n < 300) begin
      tick();
      n++;
    end
    repeat (2) tick();
    check(tag, start_cnt - base, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_core_start"}, core_start, 0);
    check({tag, "_ram_we"},     ram_we, 0);
    check({tag, "_tx_start"},   tx_start, 0);
    check({tag, "_busy"},       busy, 0);
    check({tag, "_overrun"},    overrun, 0);
    check({tag, "_digit_led"},  digit_led, 0);
    check({tag, "_tx_data"},    tx_data, 0);
    check({tag, "_ram_addr"},   ram_addr, 0);
    check({tag, "_ram_d"},      ram_d, 0);
  endtask

  // Classify with an idle transmitter that never raises busy.
  task automatic classify_quick(input string tag, input logic [3:0] d, input logic [7:0] ascii);
    int base;
    base = txs_cnt;
    core_digit = d;
    core_done  = 1'b1;
    tick();
    core_done  = 1'b0;
    check({tag, "_digit"},   digit_led, 32'(d));
    check({tag, "_tx_data"}, tx_data, 32'(ascii));
    check({tag, "_tx_start"}, tx_start, 1);
    repeat (2) tick();
    check({tag, "_busy_wait"}, busy, 1);
    tick();
    check({tag, "_idle"}, busy, 0);
    check({tag, "_tx_cnt"}, txs_cnt - base, 1);
  endtask

  initial begin
    int base_we, base_st, base_tx, errs;
    logic [7:0] pat;

    rst_n = 1'b0; rx_rdy = 1'b0; rx_data = 8'h00; core_addr = 10'h000;
    core_done = 1'b0; core_digit = 4'd0; tx_busy = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = 1'bx;
    repeat (3) tick();
    check_reset_outputs("rst0");
    rst_n = 1'b1;
    repeat (2) tick();

    // Image 1: 98 x A5 spaced 20 cycles.
    base_we = we_cnt; base_st = start_cnt;
    for (int k = 0; k < 98; k++) send_byte(8'hA5, 19);
    wait_start("img1_start", base_st);
    check("img1_we_cnt", we_cnt - base_we, 784);
    check("img1_start_lat", start_cyc - last_we_cyc, 1);
    check("img1_mem0", mem[0], 1);
    check("img1_mem1", mem[1], 0);
    check("img1_mem783", mem[783], 1);
    pat = 8'hA5;
    errs = 0;
    for (int i = 0; i < 784; i++) if (mem[i] !== pat[i % 8]) errs++;
    check("img1_pattern", errs, 0);
    check("img1_overrun", overrun, 0);

    core_addr = 10'h123;
    #1;
    check("run_addr_mux", ram_addr, 10'h123);
    check("run_we", ram_we, 0);
    check("run_busy", busy, 1);

    // Digit 7 with transmitter busy for 5 cycles.
    base_tx = txs_cnt;
    tx_busy = 1'b1;
    core_digit = 4'd7; core_done = 1'b1;
    tick();
    core_done = 1'b0;
    check("tx7_digit", digit_led, 7);
    check("tx7_held", tx_start, 0);
    check("tx7_data", tx_data, 8'h37);
    repeat (4) tick();
    check("tx7_still_held", txs_cnt - base_tx, 0);
    tx_busy = 1'b0;
    #1;
    check("tx7_pulse", tx_start, 1);
    tick();
    check("tx7_single", tx_start, 0);
    tx_busy = 1'b1;
    repeat (3) tick();
    check("tx7_wait", busy, 1);
    tx_busy = 1'b0;
    tick();
    check("tx7_idle", busy, 0);
    check("tx7_cnt", txs_cnt - base_tx, 1);
    check("tx7_data_stable", tx_data, 8'h37);

    // Image 2: two back-to-back bytes, then 96 spaced.
    base_we = we_cnt; base_st = start_cnt;
    rx_rdy = 1'b1; rx_data = 8'h01; tick();
    rx_data = 8'h80; tick();
    rx_rdy = 1'b0;
    repeat (20) tick();
    check("b2b_overrun", overrun, 0);
    check("b2b_we16", we_cnt - base_we, 16);
    for (int k = 0; k < 96; k++) send_byte(8'hFF, 19);
    wait_start("img2_start", base_st);
    check("img2_we_cnt", we_cnt - base_we, 784);
    check("img2_mem0", mem[0], 1);
    check("img2_mem7", mem[7], 0);
    check("img2_mem15", mem[15], 1);
    check("img2_mem16", mem[16], 1);
    check("img2_overrun0", overrun, 0);

    // rx_rdy while the core runs is dropped.
    base_we = we_cnt;
    core_addr = 10'h055;
    send_byte(8'h33, 2);
    check("run_rx_overrun", overrun, 1);
    check("run_rx_no_we", we_cnt - base_we, 0);
    check("run_addr2", ram_addr, 10'h055);
    classify_quick("img2_tx", 4'd3, 8'h33);

    // Image 3: three pulses on consecutive cycles, third dropped.
    base_we = we_cnt; base_st = start_cnt;
    rx_rdy = 1'b1; rx_data = 8'h0F; tick();
    rx_data = 8'hF0; tick();
    rx_data = 8'hAA; tick();
    rx_rdy = 1'b0;
    repeat (25) tick();
    check("drop_we16", we_cnt - base_we, 16);
    check("drop_busy", busy, 1);
    check("drop_mem8", mem[8], 0);
    check("drop_mem15", mem[15], 1);
    for (int k = 0; k < 96; k++) send_byte(8'h5A, 19);
    wait_start("img3_start", base_st);
    check("img3_we_cnt", we_cnt - base_we, 784);
    classify_quick("img3_tx", 4'd9, 8'h39);

    // Image 4: reset after byte 50, then a full image.
    for (int k = 0; k < 50; k++) send_byte(8'h3C, 19);
    send_byte(8'h3C, 3);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    check("rst_mid_busy_hold", busy, 0);
    rst_n = 1'b1;
    tick();
    base_we = we_cnt; base_st = start_cnt;
    for (int k = 0; k < 98; k++) send_byte(8'h96, 19);
    wait_start("img4_start", base_st);
    check("img4_first_addr", first_addr, 0);
    check("img4_we_cnt", we_cnt - base_we, 784);
    check("img4_mem0", mem[0], 0);
    check("img4_mem1", mem[1], 1);
    check("img4_mem783", mem[783], 1);
    check("img4_overrun", overrun, 0);
    classify_quick("img4_tx", 4'd12, 8'h3C);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
